// File: rtl/rr_pkg.sv
// Shared constants and types for the register-read stage.
package rr_pkg;

  localparam int RR_DW    = 16;
  localparam int RR_NREG  = 8;
  localparam int RR_IMM_S = 6;
  localparam int RR_IMM_L = 9;
  localparam int PC_REG   = RR_NREG - 1;

  typedef enum logic {
    IMM_SHORT = 1'b0,
    IMM_LONG  = 1'b1
  } imm_sel_e;

  // Index of the PC-shadow register for an arbitrary register count.
  function automatic int pc_reg_idx(input int nreg);
    return nreg - 1;
  endfunction

endpackage

// File: rtl/reg_file_p.sv
// Architectural register file: NREG x DW storage, writeback/PC-shadow write
// priority, and the optional write-to-read bypass.
// Config macro: RR_BYPASS_EN (reads see same-cycle writes when defined).
module reg_file_p
  import rr_pkg::*;
#(
  parameter int DW   = RR_DW,
  parameter int NREG = RR_NREG,
  parameter int AW   = $clog2(NREG)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wb_we,
  input  logic [AW-1:0]    rf_a3,
  input  logic [DW-1:0]    wb_data,
  input  logic             pc_we,
  input  logic [DW-1:0]    pc_data,
  input  logic [AW-1:0]    rf_a1,
  input  logic [AW-1:0]    rf_a2,
  output logic [DW-1:0]    rd1,
  output logic [DW-1:0]    rd2,
  output logic [NREG*DW-1:0] reg_dump
);

  localparam logic [AW-1:0] PC_ADDR = AW'(pc_reg_idx(NREG));

  logic [DW-1:0] regs [NREG];

  // Storage update: writeback beats the PC-shadow write on the last register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NREG; i++) regs[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < NREG; i++) begin
        if (wb_we && rf_a3 == AW'(i))
          regs[i] <= wb_data;
        else if (pc_we && AW'(i) == PC_ADDR)
          regs[i] <= pc_data;
      end
    end
  end

  // Read ports, optionally forwarding the write data of this cycle.
  always_comb begin
    rd1 = regs[rf_a1];
    rd2 = regs[rf_a2];
`ifdef RR_BYPASS_EN
    if (wb_we && rf_a3 == rf_a1)           rd1 = wb_data;
    else if (pc_we && rf_a1 == PC_ADDR)    rd1 = pc_data;
    if (wb_we && rf_a3 == rf_a2)           rd2 = wb_data;
    else if (pc_we && rf_a2 == PC_ADDR)    rd2 = pc_data;
`endif
  end

  // Debug view of the live register contents, R0 in the LSBs.
  always_comb begin
    reg_dump = '0;
    for (int unsigned i = 0; i < NREG; i++) reg_dump[i*DW +: DW] = regs[i];
  end

endmodule

// File: rtl/reg_read_stage_p.sv
// Register-read stage: register file, immediate formation, PC-relative
// target, and a valid/ready output register with stall and flush.
// Config macro: RR_BYPASS_EN (write-to-read bypass in the register file).
module reg_read_stage_p
  import rr_pkg::*;
#(
  parameter int DW    = RR_DW,
  parameter int NREG  = RR_NREG,
  parameter int AW    = $clog2(NREG),
  parameter int IMM_S = RR_IMM_S,
  parameter int IMM_L = RR_IMM_L
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DW-1:0]      inst,
  input  logic [DW-1:0]      pc_in,
  input  logic [AW-1:0]      rf_a1,
  input  logic [AW-1:0]      rf_a2,
  input  logic               imm_sel,
  input  logic               flush,
  input  logic               wb_we,
  input  logic [AW-1:0]      rf_a3,
  input  logic [DW-1:0]      wb_data,
  input  logic               pc_we,
  input  logic [DW-1:0]      pc_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DW-1:0]      out_pc,
  output logic [DW-1:0]      out_pc_imm,
  output logic [DW-1:0]      out_imm,
  output logic [DW-1:0]      out_zpad,
  output logic [DW-1:0]      out_d1,
  output logic [DW-1:0]      out_d2,
  output logic [NREG*DW-1:0] reg_dump
);

  logic [DW-1:0] rd1, rd2;
  logic [DW-1:0] imm_s, imm_l, imm, pc_imm, zpad;
  logic          accept;
  logic          unused_inst_hi;

  reg_file_p #(
    .DW  (DW),
    .NREG(NREG),
    .AW  (AW)
  ) u_rf (
    .clk     (clk),
    .reset_n (reset_n),
    .wb_we   (wb_we),
    .rf_a3   (rf_a3),
    .wb_data (wb_data),
    .pc_we   (pc_we),
    .pc_data (pc_data),
    .rf_a1   (rf_a1),
    .rf_a2   (rf_a2),
    .rd1     (rd1),
    .rd2     (rd2),
    .reg_dump(reg_dump)
  );

  // Instruction bits above the long immediate are not used by this stage.
  assign unused_inst_hi = ^inst[DW-1:IMM_L];

  // Immediate forms and PC-relative target (carry out discarded).
  always_comb begin
    imm_s  = {{(DW-IMM_S){inst[IMM_S-1]}}, inst[IMM_S-1:0]};
    imm_l  = {{(DW-IMM_L){inst[IMM_L-1]}}, inst[IMM_L-1:0]};
    imm    = (imm_sel_e'(imm_sel) == IMM_LONG) ? imm_l : imm_s;
    zpad   = {inst[IMM_L-1:0], {(DW-IMM_L){1'b0}}};
    pc_imm = pc_in + imm;
  end

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Output pipeline register: flush kills, accept loads, drain clears valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid  <= 1'b0;
      out_pc     <= '0;
      out_pc_imm <= '0;
      out_imm    <= '0;
      out_zpad   <= '0;
      out_d1     <= '0;
      out_d2     <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid  <= 1'b1;
      out_pc     <= pc_in;
      out_pc_imm <= pc_imm;
      out_imm    <= imm;
      out_zpad   <= zpad;
      out_d1     <= rd1;
      out_d2     <= rd2;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_reg_read_stage_p.sv
// Self-checking bench for reg_read_stage_p (default parameters).
module tb_reg_read_stage_p;

  localparam int DW = 16;
  localparam int NREG = 8;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0, in_ready;
  logic [DW-1:0] inst = '0, pc_in = '0;
  logic [AW-1:0] rf_a1 = '0, rf_a2 = '0, rf_a3 = '0;
  logic imm_sel = 1'b0, flush = 1'b0, wb_we = 1'b0, pc_we = 1'b0;
  logic [DW-1:0] wb_data = '0, pc_data = '0;
  logic out_valid, out_ready = 1'b1;
  logic [DW-1:0] out_pc, out_pc_imm, out_imm, out_zpad, out_d1, out_d2;
  logic [NREG*DW-1:0] reg_dump;

  int vectors = 0;
  int errors = 0;

  reg_read_stage_p #(
    .DW(DW), .NREG(NREG), .AW(AW), .IMM_S(6), .IMM_L(9)
  ) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .inst(inst), .pc_in(pc_in), .rf_a1(rf_a1), .rf_a2(rf_a2),
    .imm_sel(imm_sel), .flush(flush), .wb_we(wb_we), .rf_a3(rf_a3),
    .wb_data(wb_data), .pc_we(pc_we), .pc_data(pc_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_pc_imm(out_pc_imm), .out_imm(out_imm), .out_zpad(out_zpad),
    .out_d1(out_d1), .out_d2(out_d2), .reg_dump(reg_dump)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: plain arithmetic over an array of registers.
  logic [DW-1:0] m_rf [NREG] = '{default: '0};
  logic m_valid = 1'b0;
  logic [DW-1:0] m_pc = '0, m_pc_imm = '0, m_imm = '0, m_zpad = '0, m_d1 = '0, m_d2 = '0;
  logic [DW-1:0] t_d1, t_d2, t_imm;
  logic t_acc;

  function automatic logic [DW-1:0] sext(input logic [DW-1:0] v, input int bits);
    int s;
    s = int'(v) % (1 << bits);
    if (s >= (1 << (bits - 1))) s = s - (1 << bits);
    return DW'(s);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREG; i++) m_rf[i] = '0;
      m_valid = 0; m_pc = 0; m_pc_imm = 0; m_imm = 0; m_zpad = 0; m_d1 = 0; m_d2 = 0;
    end else begin
      t_acc = in_valid && (!m_valid || out_ready);
      t_d1 = m_rf[rf_a1];
      t_d2 = m_rf[rf_a2];
`ifdef RR_BYPASS_EN
      if (pc_we && int'(rf_a1) == NREG - 1) t_d1 = pc_data;
      if (pc_we && int'(rf_a2) == NREG - 1) t_d2 = pc_data;
      if (wb_we && rf_a3 == rf_a1) t_d1 = wb_data;
      if (wb_we && rf_a3 == rf_a2) t_d2 = wb_data;
`endif
      t_imm = imm_sel ? sext(inst, 9) : sext(inst, 6);
      if (flush) m_valid = 0;
      else if (t_acc) begin
        m_valid = 1;
        m_pc = pc_in;
        m_imm = t_imm;
        m_pc_imm = DW'((int'(pc_in) + int'(t_imm)) % 65536);
        m_zpad = DW'((int'(inst) % 512) * 128);
        m_d1 = t_d1;
        m_d2 = t_d2;
      end else if (out_ready) m_valid = 0;
      if (pc_we) m_rf[NREG-1] = pc_data;
      if (wb_we) m_rf[rf_a3] = wb_data;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    logic [NREG*DW-1:0] exp_dump;
    for (int i = 0; i < NREG; i++) exp_dump[i*DW +: DW] = m_rf[i];
    chk("m_reg_dump", reg_dump, exp_dump);
    chk("m_out_valid", out_valid, m_valid);
    chk("m_in_ready", in_ready, !m_valid || out_ready);
    if (m_valid) begin
      chk("m_out_pc", out_pc, m_pc);
      chk("m_out_pc_imm", out_pc_imm, m_pc_imm);
      chk("m_out_imm", out_imm, m_imm);
      chk("m_out_zpad", out_zpad, m_zpad);
      chk("m_out_d1", out_d1, m_d1);
      chk("m_out_d2", out_d2, m_d2);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_reg_dump", reg_dump, '0);
    chk("rst_out_d1", out_d1, '0);
    @(negedge clk);
    reset_n = 1'b1;
    tick();

    // Write R3, then read it back through the pipeline register
    wb_we = 1; rf_a3 = 3; wb_data = 16'h1234;
    tick();
    wb_we = 0; in_valid = 1; rf_a1 = 3; rf_a2 = 0;
    inst = 16'h003F; imm_sel = 0; pc_in = 16'h0010;
    tick();
    chk("lit_valid", out_valid, 1'b1);
    chk("lit_d1_r3", out_d1, 16'h1234);
    chk("lit_imm_s", out_imm, 16'hFFFF);
    chk("lit_pc_imm", out_pc_imm, 16'h000F);

    inst = 16'h0100; imm_sel = 1;
    tick();
    chk("lit_imm_l", out_imm, 16'hFF00);
    chk("lit_pc_imm_l", out_pc_imm, 16'hFF10);

    inst = 16'h01FF;
    tick();
    chk("lit_zpad", out_zpad, 16'hFF80);

    inst = 16'h0001; imm_sel = 0; pc_in = 16'hFFFF;
    tick();
    chk("lit_wrap", out_pc_imm, 16'h0000);
    chk("lit_imm_one", out_imm, 16'h0001);

    // Same-cycle writeback and PC-shadow write to R7
    wb_we = 1; rf_a3 = 7; wb_data = 16'hAAAA;
    pc_we = 1; pc_data = 16'h5555;
    rf_a1 = 7; rf_a2 = 7; inst = 16'h0002; pc_in = 16'h0040;
    tick();
`ifdef RR_BYPASS_EN
    chk("lit_byp_d1", out_d1, 16'hAAAA);
`else
    chk("lit_byp_d1", out_d1, 16'h0000);
`endif
    chk("lit_r7", reg_dump[127:112], 16'hAAAA);
    wb_we = 0; pc_we = 0;

    // Stall with a flush in the second cycle
    out_ready = 0; pc_in = 16'h0123;
    tick();
    chk("lit_stall_ready", in_ready, 1'b0);
    chk("lit_stall_pc", out_pc, 16'h0040);
    chk("lit_stall_pci", out_pc_imm, 16'h0042);
    flush = 1;
    tick();
    chk("lit_flush_valid", out_valid, 1'b0);
    flush = 0;
    tick();
    chk("lit_post_flush", out_pc, 16'h0123);
    out_ready = 1;
    tick();

    // Randomised traffic
    for (int n = 0; n < 600; n++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      wb_we     = $urandom_range(0, 1);
      pc_we     = ($urandom_range(0, 9) < 3);
      rf_a1     = AW'($urandom_range(0, NREG - 1));
      rf_a2     = AW'($urandom_range(0, NREG - 1));
      rf_a3     = AW'($urandom_range(0, NREG - 1));
      wb_data   = DW'($urandom);
      pc_data   = DW'($urandom);
      inst      = DW'($urandom);
      pc_in     = DW'($urandom);
      imm_sel   = $urandom_range(0, 1);
      tick();
    end

    // Asynchronous reset while holding a valid instruction
    flush = 0; wb_we = 0; pc_we = 0;
    in_valid = 1; out_ready = 1; pc_in = 16'h0777; rf_a1 = 7;
    tick();
    chk("lit_pre_rst_valid", out_valid, 1'b1);
    #2;
    reset_n = 0;
    #1;
    chk("lit_arst_valid", out_valid, 1'b0);
    chk("lit_arst_pc", out_pc, '0);
    chk("lit_arst_d1", out_d1, '0);
    chk("lit_arst_dump", reg_dump, '0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1;
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
